// File: rtl/score_display.sv
// Score keeper and two-digit score renderer: frame-synchronous score commits,
// PLAY/OVER winner blink, and a 3-stage raster pipeline around a shared glyph ROM.
module score_display #(
  parameter int unsigned LEFT_X     = 280,
  parameter int unsigned RIGHT_X    = 344,
  parameter int unsigned TOP_Y      = 16,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned MAX_SCORE  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       frame_start,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       new_game,
  output logic [1:0] glyph_x,
  output logic [2:0] glyph_y,
  output logic [3:0] glyph_value,
  input  logic       glyph_pixel,
  output logic       pixel_on,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);

  localparam int unsigned BOX_W = 3 << SCALE_LOG2;
  localparam int unsigned BOX_H = 5 << SCALE_LOG2;
  localparam logic [3:0]  MAX4  = 4'(MAX_SCORE);

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       pend_l_q, pend_l_d;
  logic       pend_r_q, pend_r_d;
  logic       pend_ng_q, pend_ng_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       game_over_q;

  logic       take_l, take_r, take_ng;

  assign take_l  = pend_l_q  | point_left;
  assign take_r  = pend_r_q  | point_right;
  assign take_ng = pend_ng_q | new_game;

  // Score/state next-state: pulses accumulate, everything commits on frame_start.
  always_comb begin
    pend_l_d    = take_l;
    pend_r_d    = take_r;
    pend_ng_d   = take_ng;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      pend_l_d    = 1'b0;
      pend_r_d    = 1'b0;
      pend_ng_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 5'd1;
      if (take_ng) begin
        score_l_d = 4'd0;
        score_r_d = 4'd0;
        state_d   = ST_PLAY;
      end else if (state_q == ST_PLAY) begin
        score_l_d = score_l_q + {3'd0, take_l};
        score_r_d = score_r_q + {3'd0, take_r};
        if ((score_l_d == MAX4) || (score_r_d == MAX4)) begin
          state_d     = ST_OVER;
          frame_cnt_d = 5'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      pend_l_q    <= 1'b0;
      pend_r_q    <= 1'b0;
      pend_ng_q   <= 1'b0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      frame_cnt_q <= 5'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_ng_q   <= pend_ng_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      frame_cnt_q <= frame_cnt_d;
      game_over_q <= (state_d == ST_OVER);
    end
  end

  // Stage 0: raster position to digit cell and glyph address.
  logic [9:0] dxl, dxr, dy, dx_sel;
  logic       in_left, in_right, in_box, hide_l, hide_r, hidden;
  logic [1:0] gx_d;
  logic [2:0] gy_d;
  logic [3:0] gv_d;
  logic       vis1_d;

  assign dxl      = hpos - 10'(LEFT_X);
  assign dxr      = hpos - 10'(RIGHT_X);
  assign dy       = vpos - 10'(TOP_Y);
  assign in_left  = (dxl < 10'(BOX_W)) && (dy < 10'(BOX_H));
  assign in_right = (dxr < 10'(BOX_W)) && (dy < 10'(BOX_H));
  assign in_box   = in_left | in_right;
  assign dx_sel   = in_left ? dxl : dxr;
  assign hide_l   = (state_q == ST_OVER) && (score_l_q == MAX4) && frame_cnt_q[4];
  assign hide_r   = (state_q == ST_OVER) && (score_r_q == MAX4) && frame_cnt_q[4];
  assign hidden   = in_left ? hide_l : hide_r;

  always_comb begin
    gx_d   = 2'd0;
    gy_d   = 3'd0;
    gv_d   = 4'd0;
    vis1_d = 1'b0;
    if (in_box) begin
      gx_d   = 2'(dx_sel >> SCALE_LOG2);
      gy_d   = 3'(dy >> SCALE_LOG2);
      gv_d   = in_left ? score_l_q : score_r_q;
      vis1_d = !hidden;
    end
  end

  // Stages 1-3: address out, wait for ROM, gate returned glyph bit.
  logic [1:0] glyph_x_q;
  logic [2:0] glyph_y_q;
  logic [3:0] glyph_value_q;
  logic       vis1_q, vis2_q, pixel_on_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_x_q     <= 2'd0;
      glyph_y_q     <= 3'd0;
      glyph_value_q <= 4'd0;
      vis1_q        <= 1'b0;
      vis2_q        <= 1'b0;
      pixel_on_q    <= 1'b0;
    end else begin
      glyph_x_q     <= gx_d;
      glyph_y_q     <= gy_d;
      glyph_value_q <= gv_d;
      vis1_q        <= vis1_d;
      vis2_q        <= vis1_q;
      pixel_on_q    <= vis2_q & glyph_pixel;
    end
  end

  assign glyph_x     = glyph_x_q;
  assign glyph_y     = glyph_y_q;
  assign glyph_value = glyph_value_q;
  assign pixel_on    = pixel_on_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign game_over   = game_over_q;

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Owns both player scores and schedules the shared 3x5 digit glyph lookup (value 0-9, xpos 0-2, ypos 0-4, one registered clock of latency) for the two on-screen score digits.
- Maps the raster position to a digit cell and glyph address, drives the lookup, and re-aligns the returned glyph bit into a pixel_on output for the video mixer.
- Holds score updates until frame_start so digits never tear mid-frame.
- Runs a small PLAY/OVER state machine that blinks the winner's digit.

Parameters:
- LEFT_X, 280, hpos of left digit box left edge
- RIGHT_X, 344, hpos of right digit box left edge
- TOP_Y, 16, vpos of both digit boxes' top edge
- SCALE_LOG2, 3, log2 of screen pixels per glyph pixel (box = (3<<S) x (5<<S))
- MAX_SCORE, 9, winning score (1..9)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hpos  in  10  current raster x
- vpos  in  10  current raster y
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- point_left  in  1  one-cycle pulse, left player scored
- point_right  in  1  one-cycle pulse, right player scored
- new_game  in  1  one-cycle pulse, request score clear
- glyph_x  out  2  lookup xpos
- glyph_y  out  3  lookup ypos
- glyph_value  out  4  lookup value
- glyph_pixel  in  1  lookup result, valid one clk after address
- pixel_on  out  1  score pixel lit
- score_left  out  4  committed left score
- score_right  out  4  committed right score
- game_over  out  1  high in OVER state

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, pending flags 0, frame_cnt 0, state PLAY.
- Pending latches:
  - point_left, point_right and new_game each set a sticky pending flag.
  - Flags are applied and cleared only on the cycle frame_start is high.
  - A pulse coincident with frame_start is applied in that same cycle.
- Commit at frame_start:
  - new_game pending: both scores become 0, state becomes PLAY, point flags are discarded.
  - Otherwise, in PLAY: each pending side increments by 1. Simultaneous points increment both.
  - If either score reaches MAX_SCORE, state becomes OVER and frame_cnt clears.
  - If both reach MAX_SCORE together, both are winners.
  - In OVER, point flags are discarded and scores do not change.
- frame_cnt: 5 bits, increments on every frame_start, wraps 31->0.
- Blink: in OVER, a winner's digit is hidden while frame_cnt[4]=1. game_over = (state==OVER).
- Pixel pipeline, for a raster position at cycle N:
  - Stage 0, combinational: dxl=hpos-LEFT_X, dxr=hpos-RIGHT_X, dy=vpos-TOP_Y, all unsigned 10-bit.
  - in_left = dxl<(3<<S) && dy<(5<<S). in_right is the same using dxr. Left wins if the boxes overlap.
  - Stage 1, registered, valid at N+1: glyph_x=dx>>S and glyph_y=dy>>S for the selected box, glyph_value = that side's score, vis1 = in_box && !hidden.
  - When no box is hit, glyph_x/glyph_y/glyph_value are driven 0.
  - Stage 2: vis2 <= vis1. glyph_pixel is valid at N+2.
  - Stage 3: pixel_on <= vis2 & glyph_pixel, valid at N+3. Total latency 3 clocks, fully pipelined, one pixel per clock.
- Score changes take effect in stage 1 only. They are committed during blanking, so no visible digit changes mid-frame.
- Reset mid-frame clears the pipeline: pixel_on stays 0 for at least 3 cycles after rst_n rises.

Test Plan:
- Reset: assert rst_n=0 mid-pipeline -> all outputs 0 immediately; after release with hpos outside boxes, pixel_on=0.
- Deferred update: point_left at cycle 100, frame_start at 500 -> score_left 0 through cycle 500, 1 from cycle 501; score_right stays 0.
- Simultaneous events: point_left, point_right and frame_start in one cycle, scores 3/5 -> 4/6. new_game plus point_left pending at frame_start -> 0/0, PLAY.
- Win and blink: left at 8, point_left, frame_start -> score_left=9, game_over=1, frame_cnt=0. Further point_right -> score_right unchanged. Over frames 16-31 left digit pixel_on=0; right digit still drawn.
- Pipeline, S=3, score_left=1: hpos=LEFT_X+8, vpos=TOP_Y at N -> at N+1 glyph_x=1, glyph_y=0, glyph_value=1; bench returns glyph_pixel=1 at N+2 -> pixel_on=1 at N+3.
- Box edges: hpos=LEFT_X+24 or vpos=TOP_Y+40 with glyph_pixel forced 1 -> pixel_on=0. hpos=LEFT_X+23, vpos=TOP_Y+39 -> glyph_x=2, glyph_y=4.
